// File: rtl/chip8_loader_pkg.sv
// Shared types and constants for the CHIP-8 program loader.
package chip8_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT      = 8'hC8;
    localparam int         LOAD_BASE_DEFAULT = 512;

    // A length is usable when it is non-zero and the image still ends inside memory.
    function automatic logic len_ok(input logic [15:0] len, input int unsigned max_len);
        return (len != 16'd0) && ({16'd0, len} <= max_len);
    endfunction

endpackage

// File: rtl/chip8_loader_byte_timeout.sv
// Inter-byte idle counter: expire is raised on the cycle the count would reach TIMEOUT_CYCLES.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A clear on the expiring cycle suppresses the expiry, so a late-but-in-time byte wins.
    assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/chip8_loader.sv
// Parses SYNC/LEN/payload/CSUM frames from the UART byte stream into program memory and gates run.
module chip8_loader
    import chip8_loader_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         ADDR_WIDTH     = 12,
    parameter int         LOAD_BASE      = LOAD_BASE_DEFAULT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_i,
    input  logic                  rx_i_v,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] d,
    output logic                  run,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int unsigned MAX_LEN = (1 << ADDR_WIDTH) - LOAD_BASE;

    state_t                state;
    logic [7:0]            len_hi;
    logic [15:0]           len;
    logic [15:0]           idx;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] sum_next;
    logic [15:0]           len_rx;
    logic                  tmo_en;
    logic                  expire;

    assign sum_next = sum + rx_i;
    assign len_rx   = {len_hi, rx_i[7:0]};
    assign tmo_en   = (state != ST_IDLE);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rx_i_v),
        .en    (tmo_en),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_hi   <= '0;
            len      <= '0;
            idx      <= '0;
            sum      <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            d        <= '0;
            run      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            if (rx_i_v) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_i[7:0] == SYNC_BYTE) begin
                            run      <= 1'b0;
                            err_code <= ERR_NONE;
                            sum      <= '0;
                            state    <= ST_LEN_H;
                        end
                    end
                    ST_LEN_H: begin
                        len_hi <= rx_i[7:0];
                        state  <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        if (len_ok(len_rx, MAX_LEN)) begin
                            len   <= len_rx;
                            idx   <= '0;
                            state <= ST_DATA;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_LEN;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        we    <= 1'b1;
                        waddr <= ADDR_WIDTH'(LOAD_BASE) + ADDR_WIDTH'(idx);
                        d     <= rx_i;
                        sum   <= sum_next;
                        idx   <= idx + 16'd1;
                        if (idx == len - 16'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (sum_next == '0) begin
                            done <= 1'b1;
                            run  <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_chip8_loader.sv
// Randomized frame stimulus with an event scoreboard for the CHIP-8 program loader.
module tb_chip8_loader;

    localparam int TMO = 16;
    localparam int EW  = 44;  // {kind[2], addr[12], data[8], code[2], cycle[20]}
    localparam logic [1:0] K_NONE = 2'd0, K_WR = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_i;
    logic        rx_i_v;
    logic        we;
    logic [11:0] waddr;
    logic [7:0]  d;
    logic        run;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int force_gap = -1;
    logic [EW-1:0] exp_q[$];

    chip8_loader #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_i    (rx_i),
        .rx_i_v  (rx_i_v),
        .we      (we),
        .waddr   (waddr),
        .d       (d),
        .run     (run),
        .done    (done),
        .err     (err),
        .err_code(err_code)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [EW-1:0] mk(input logic [1:0] kind, input logic [11:0] addr,
                                          input logic [7:0] data, input logic [1:0] code);
        return {kind, addr, data, code, 20'd0};
    endfunction

    function automatic int gap_pick();
        int r;
        if (force_gap >= 0) return force_gap;
        r = $urandom_range(0, 15);
        if (r == 0) return TMO - 1;
        if (r < 10) return 0;
        return $urandom_range(1, 3);
    endfunction

    // driver: one strobe after gap idle cycles; any expected event is stamped with its output cycle
    task automatic send_byte(input logic [7:0] b, input int gap, input logic [EW-1:0] ev, output int sc);
        repeat (gap) @(negedge clk);
        rx_i   = b;
        rx_i_v = 1'b1;
        sc     = cyc + 1;
        if (ev[43:42] != K_NONE) exp_q.push_back({ev[43:20], 20'(sc)});
        @(negedge clk);
        rx_i_v = 1'b0;
    endtask

    // reference model: frame outcome derived directly from the framing rules
    task automatic send_frame(input logic [15:0] len, input logic [7:0] pl[$], input logic [7:0] cs,
                              input int stall_at);
        int sc;
        logic [7:0] s;
        logic [7:0] t;
        logic [EW-1:0] tev;
        bit ok;
        s  = 8'd0;
        ok = (len >= 16'd1) && (len <= 16'd3584);
        send_byte(8'hC8, gap_pick(), mk(K_NONE, 0, 0, 0), sc);
        send_byte(len[15:8], gap_pick(), mk(K_NONE, 0, 0, 0), sc);
        send_byte(len[7:0], gap_pick(), ok ? mk(K_NONE, 0, 0, 0) : mk(K_ERR, 0, 0, 2'd1), sc);
        if (!ok) return;
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i], gap_pick(), mk(K_WR, 12'(512 + i), pl[i], 0), sc);
            s = s + pl[i];
            if (i == stall_at) begin
                tev = mk(K_ERR, 0, 0, 2'd3);
                exp_q.push_back({tev[43:20], 20'(sc + TMO)});
                repeat (TMO + 4) @(negedge clk);
                return;
            end
        end
        t = s + cs;
        send_byte(cs, gap_pick(), (t == 8'd0) ? mk(K_DONE, 0, 0, 0) : mk(K_ERR, 0, 0, 2'd2), sc);
    endtask

    function automatic logic [7:0] good_cs(input logic [7:0] pl[$]);
        logic [7:0] s;
        s = 8'd0;
        foreach (pl[i]) s = s + pl[i];
        return 8'd0 - s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_d"}, d, 0);
        chk({tag, "_run"}, run, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [1:0] kobs;
        if (we || done || err) begin
            chk("done_err_exclusive", done & err, 0);
            kobs = we ? K_WR : (done ? K_DONE : K_ERR);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", kobs, K_NONE);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kobs, e[43:42]);
                chk("event_cycle", cyc, e[19:0]);
                case (e[43:42])
                    K_WR: begin
                        chk("waddr", waddr, e[41:30]);
                        chk("wdata", d, e[29:22]);
                    end
                    K_DONE: chk("run_after_done", run, 1);
                    default: begin
                        chk("err_code", err_code, e[21:20]);
                        chk("run_after_err", run, 0);
                    end
                endcase
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] cs;
        logic [15:0] len;
        int sc;
        int r;
        rst_n  = 1'b0;
        rx_i   = 8'd0;
        rx_i_v = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // good 3-byte frame on back-to-back strobes; checksum byte makes the frame sum to zero
        force_gap = 0;
        pl = '{8'h12, 8'h34, 8'h56};
        send_frame(16'd3, pl, good_cs(pl), -1);
        repeat (3) @(negedge clk);
        chk("run_held", run, 1);
        send_frame(16'd3, pl, good_cs(pl) + 8'd1, -1);

        // length rejects, then a good frame
        send_frame(16'd0, pl, 8'd0, -1);
        send_frame(16'h0E01, pl, 8'd0, -1);
        send_frame(16'd3, pl, good_cs(pl), -1);

        // timeout after one data byte, then a frame using the maximum in-time gap everywhere
        pl = '{8'h11, 8'h22};
        send_frame(16'd2, pl, good_cs(pl), 0);
        force_gap = TMO - 1;
        send_frame(16'd2, pl, good_cs(pl), -1);
        force_gap = 0;

        // reset mid-DATA abandons the frame
        send_byte(8'hC8, 0, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'h00, 0, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'h04, 0, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'hAA, 0, mk(K_WR, 12'h200, 8'hAA, 0), sc);
        send_byte(8'hBB, 0, mk(K_WR, 12'h201, 8'hBB, 0), sc);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        send_byte(8'hCC, 0, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'hDD, 1, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'h99, 0, mk(K_NONE, 0, 0, 0), sc);

        // junk before SYNC, SYNC value as payload
        send_byte(8'h00, 0, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'hFF, 2, mk(K_NONE, 0, 0, 0), sc);
        send_byte(8'h12, 0, mk(K_NONE, 0, 0, 0), sc);
        pl = '{8'hC8, 8'h01, 8'hC8};
        send_frame(16'd3, pl, good_cs(pl), -1);

        // largest image: last write lands on the top address
        pl = {};
        for (int i = 0; i < 3584; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(16'd3584, pl, good_cs(pl), -1);
        force_gap = -1;

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 2);
            for (int j = 0; j < r; j++)
                send_byte(8'($urandom_range(0, 199)), gap_pick(), mk(K_NONE, 0, 0, 0), sc);
            pl = {};
            len = 16'($urandom_range(1, 6));
            for (int i = 0; i < int'(len); i++)
                pl.push_back(($urandom_range(0, 5) == 0) ? 8'hC8 : 8'($urandom_range(0, 255)));
            cs = good_cs(pl);
            r = $urandom_range(0, 9);
            case (r)
                0: begin
                    case ($urandom_range(0, 2))
                        0: len = 16'd0;
                        1: len = 16'd3585;
                        default: len = 16'($urandom_range(3586, 65535));
                    endcase
                    send_frame(len, pl, cs, -1);
                end
                1: send_frame(len, pl, cs ^ 8'($urandom_range(1, 255)), -1);
                2: send_frame(len, pl, cs, $urandom_range(0, int'(len) - 1));
                default: send_frame(len, pl, cs, -1);
            endcase
        end

        repeat (40) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
